// File: rtl/logic_seq_pkg.sv
// rtl/logic_seq_pkg.sv - shared types and constants for the logic-op sweep sequencer
package logic_seq_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_e;

  localparam int NUM_VEC = 8;
  localparam int IDX_W   = 3;

  // Gated XNOR: y = sel & (a ~^ b), so only vectors 1 and 7 read back 1.
  localparam logic [NUM_VEC-1:0] XNOR_GATED_TBL = 8'h82;

endpackage

// File: rtl/seq_hold_timer.sv
// rtl/seq_hold_timer.sv - loadable down-counter that paces how long each vector settles
module seq_hold_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] value_o,
  output logic         zero_o
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (dec_i && (value_q != '0)) begin
      value_d = value_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign zero_o  = (value_q == '0);

endmodule

// File: rtl/logic_op_sequencer.sv
// rtl/logic_op_sequencer.sv - sweeps all 8 operand vectors through the mux stage and packs a truth table
// Optional golden-table compare with pass/fail outputs is enabled by SEQ_SELF_CHECK_EN.
module logic_op_sequencer
  import logic_seq_pkg::*;
#(
  parameter int                   HOLD_CYCLES  = 2,
  parameter logic [NUM_VEC-1:0]   EXPECTED_TBL = XNOR_GATED_TBL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               op_a,
  output logic               op_b,
  output logic               op_sel,
  input  logic               y_in,
  output logic [NUM_VEC-1:0] table_out
`ifdef SEQ_SELF_CHECK_EN
  ,
  output logic               pass,
  output logic               fail
`endif
);

  localparam int                HW        = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0]     HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VEC - 1);

  state_e               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     op_q;
  logic [NUM_VEC-1:0]   table_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 hold_load;
  logic                 hold_dec;
  logic                 hold_zero;
  logic [HW-1:0]        hold_value;

  // Reload on sweep accept and whenever another vector follows a sample.
  assign hold_load = ((state_q == IDLE) && start) ||
                     ((state_q == SAMPLE) && (idx_q != LAST_IDX));
  assign hold_dec  = (state_q == DRIVE) && !hold_zero;

  seq_hold_timer #(.W(HW)) u_hold_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (hold_load),
    .load_val_i (HOLD_LOAD),
    .dec_i      (hold_dec),
    .value_o    (hold_value),
    .zero_o     (hold_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= DRIVE;
            idx_q   <= '0;
            op_q    <= '0;
            table_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        DRIVE: begin
          if (hold_value == '0) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          table_q[idx_q] <= y_in;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= DRIVE;
            idx_q   <= idx_q + IDX_W'(1);
            op_q    <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign op_a      = op_q[2];
  assign op_b      = op_q[1];
  assign op_sel    = op_q[0];
  assign table_out = table_q;

`ifdef SEQ_SELF_CHECK_EN
  logic pass_q;
  logic fail_q;

  // Verdict is taken in DONE, when the table is complete, and held until the next sweep starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (state_q == DONE) begin
      pass_q <= (table_q == EXPECTED_TBL);
      fail_q <= (table_q != EXPECTED_TBL);
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
`else
  logic unused_expected_tbl;
  assign unused_expected_tbl = ^EXPECTED_TBL;
`endif

endmodule

// File: tb/tb_logic_op_sequencer.sv
// tb/tb_logic_op_sequencer.sv - scoreboard bench driving two sequencers (HOLD 2 and 1) into gated-XNOR stages
module tb_logic_op_sequencer;

  typedef struct {
    int         acc;
    logic [7:0] tbl;
  } run_t;

  logic            clk     = 1'b0;
  logic            rst     = 1'b1;
  logic [1:0]      start_s = '0;
  logic [1:0]      stub_s  = '0;
  logic [1:0]      busy_s, done_s, a_s, b_s, sel_s, y_s;
  logic [1:0][7:0] tbl_s;
`ifdef SEQ_SELF_CHECK_EN
  logic [1:0]      pass_s, fail_s;
`endif

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;
  run_t q0[$];
  run_t q1[$];
  logic [7:0] last_tbl [2];
  bit         pf_valid [2];
  bit         pf_pending [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gated-XNOR mux stage, optionally stubbed to a constant 0.
  assign y_s[0] = ~stub_s[0] & sel_s[0] & ~(a_s[0] ^ b_s[0]);
  assign y_s[1] = ~stub_s[1] & sel_s[1] & ~(a_s[1] ^ b_s[1]);

  logic_op_sequencer #(.HOLD_CYCLES(2)) u_dut_h2 (
    .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .op_a(a_s[0]), .op_b(b_s[0]), .op_sel(sel_s[0]), .y_in(y_s[0]), .table_out(tbl_s[0])
`ifdef SEQ_SELF_CHECK_EN
    , .pass(pass_s[0]), .fail(fail_s[0])
`endif
  );

  logic_op_sequencer #(.HOLD_CYCLES(1)) u_dut_h1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .op_a(a_s[1]), .op_b(b_s[1]), .op_sel(sel_s[1]), .y_in(y_s[1]), .table_out(tbl_s[1])
`ifdef SEQ_SELF_CHECK_EN
    , .pass(pass_s[1]), .fail(fail_s[1])
`endif
  );

  function automatic int hold_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic [7:0] ref_table(input bit stub);
    logic [7:0] t;
    int a, b, s;
    t = '0;
    for (int v = 0; v < 8; v++) begin
      a = (v / 4) % 2;
      b = (v / 2) % 2;
      s = v % 2;
      t[v] = !stub && (s == 1) && (a == b);
    end
    return t;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic run_t qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic push_run(input int k, input int acc, input logic [7:0] tbl);
    run_t r;
    r.acc = acc;
    r.tbl = tbl;
    if (k == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic pop_run(input int k);
    if (k == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic clear_models();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      last_tbl[k]   = '0;
      pf_valid[k]   = 1'b0;
      pf_pending[k] = 1'b0;
    end
  endtask

  task automatic check(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL hold%0d %s: got 0x%0h want 0x%0h (cycle %0d)", hold_of(k), name, act, exp, cyc);
  endtask

  task automatic mon_step(input int k);
    int         p, d, idx;
    run_t       r;
    logic [7:0] mask;
    p = hold_of(k) + 1;
    if (pf_pending[k]) begin
      pf_valid[k]   = 1'b1;
      pf_pending[k] = 1'b0;
    end
    if (qsize(k) > 0) r = qfront(k);
    if ((qsize(k) > 0) && (cyc >= r.acc)) begin
      d = cyc - r.acc;
      pf_valid[k] = 1'b0;
      if (d < 8 * p) begin
        idx  = d / p;
        mask = 8'((1 << idx) - 1);
        check(k, "busy_in_sweep", busy_s[k], 1);
        check(k, "done_early", done_s[k], 0);
        check(k, "op_vector", {a_s[k], b_s[k], sel_s[k]}, idx);
        check(k, "table_partial", tbl_s[k], r.tbl & mask);
`ifdef SEQ_SELF_CHECK_EN
        check(k, "pass_in_sweep", pass_s[k], 0);
        check(k, "fail_in_sweep", fail_s[k], 0);
`endif
      end else begin
        check(k, "done_cycle", done_s[k], 1);
        check(k, "busy_at_done", busy_s[k], 0);
        check(k, "op_at_done", {a_s[k], b_s[k], sel_s[k]}, 0);
        check(k, "table_final", tbl_s[k], r.tbl);
        last_tbl[k]   = r.tbl;
        pf_pending[k] = 1'b1;
        pop_run(k);
      end
    end else begin
      check(k, "idle_busy", busy_s[k], 0);
      check(k, "idle_done", done_s[k], 0);
      check(k, "idle_op", {a_s[k], b_s[k], sel_s[k]}, 0);
      check(k, "idle_table", tbl_s[k], last_tbl[k]);
`ifdef SEQ_SELF_CHECK_EN
      check(k, "idle_pass", pass_s[k], pf_valid[k] && (last_tbl[k] == 8'h82));
      check(k, "idle_fail", fail_s[k], pf_valid[k] && (last_tbl[k] != 8'h82));
`endif
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) mon_step(k);
    end
  end

  task automatic kick(input logic [1:0] m, input bit stub);
    for (int k = 0; k < 2; k++) begin
      if (m[k]) begin
        start_s[k] = 1'b1;
        stub_s[k]  = stub;
        push_run(k, cyc + 1, ref_table(stub));
      end
    end
    @(posedge clk);
    #1;
    start_s = '0;
  endtask

  task automatic wait_idle(input int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; (i < 300) && !ok; i++) begin
      @(posedge clk);
      #1;
      if (qsize(k) == 0) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL hold%0d wait_timeout: sweep still pending after 300 cycles (cycle %0d)", hold_of(k), cyc);
      clear_models();
    end
  endtask

  initial begin
    int acc;
    logic [1:0] m;
    bit stub;
    clear_models();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    kick(2'b01, 1'b0);
    wait_idle(0);
    kick(2'b10, 1'b0);
    wait_idle(1);

    kick(2'b01, 1'b0);
    acc = cyc;
    repeat (4) @(posedge clk);
    #1;
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    while (cyc < acc + 24) begin
      @(posedge clk);
      #1;
    end
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    kick(2'b01, 1'b0);
    wait_idle(0);

    kick(2'b01, 1'b0);
    acc = cyc;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_models();
    repeat (3) @(posedge clk);
    #1;
    kick(2'b01, 1'b0);
    wait_idle(0);

    rst     = 1'b1;
    start_s = 2'b11;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    start_s = '0;
    clear_models();
    repeat (3) @(posedge clk);
    #1;

    kick(2'b11, 1'b1);
    wait_idle(0);
    wait_idle(1);
    repeat (2) @(posedge clk);
    #1;
    kick(2'b11, 1'b0);
    wait_idle(0);
    wait_idle(1);

    for (int it = 0; it < 8; it++) begin
      m    = 2'($urandom_range(1, 3));
      stub = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      kick(m, stub);
      wait_idle(0);
      wait_idle(1);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
